// File: rtl/weight_readback_tx_pkg.sv
// -----------------------------------------------------------------------------
// weight_readback_tx_pkg
// Shared definitions for the weight readback sequencer:
//   - WEIGHT_COUNT : default transfer length. This is the same weight count the
//                    load FSM uses, so load and readback lengths stay matched.
//   - rb_state_t   : 3-bit FSM state encoding.
//   - xor_accum    : running XOR checksum helper.
// -----------------------------------------------------------------------------
package weight_readback_tx_pkg;

  localparam int WEIGHT_COUNT = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    CHKSUM  = 3'd5,
    FINISH  = 3'd6
  } rb_state_t;

  // Fold one data byte into the running XOR checksum.
  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/weight_readback_tx.sv
// -----------------------------------------------------------------------------
// weight_readback_tx
// Reads NUM_BYTES bytes from the weight memory, starting at address 0, and
// hands each byte to the UART transmitter using a start/busy/done handshake.
// The host can then verify what was loaded.
//
// Optional feature: define READBACK_CHECKSUM_EN to append one extra byte after
// the data bytes. That byte is the XOR of all NUM_BYTES data bytes.
//
// Parameters:
//   NUM_BYTES  bytes per transfer (1..256)
//   ADDR_W     memory address width
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      one-cycle request; honoured only in IDLE
//   rd_en      memory read strobe (registered)
//   rd_addr    memory read address (registered)
//   rd_data    memory read data, valid one cycle after rd_en
//   tx_start   one-cycle pulse to the UART TX (registered)
//   tx_data    byte to transmit, stable from tx_start until tx_done
//   tx_busy    UART TX occupied
//   tx_done    UART TX finished a byte
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse after the final byte completes
// -----------------------------------------------------------------------------
import weight_readback_tx_pkg::*;

module weight_readback_tx #(
  parameter int NUM_BYTES = WEIGHT_COUNT,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  rb_state_t state_r;

`ifdef READBACK_CHECKSUM_EN
  logic [7:0] checksum_r;
  // Set once the checksum byte is in flight, so its tx_done ends the transfer.
  logic       chk_phase_r;
`endif

  // Readback FSM: every output is driven from this single registered process.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      checksum_r  <= 8'h00;
      chk_phase_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          tx_start <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            // The read strobe is raised on entry so it is high during FETCH.
            rd_addr     <= '0;
            rd_en       <= 1'b1;
            busy        <= 1'b1;
`ifdef READBACK_CHECKSUM_EN
            checksum_r  <= 8'h00;
            chk_phase_r <= 1'b0;
`endif
            state_r     <= FETCH;
          end else begin
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end

        FETCH: begin
          // The memory returns rd_data while the FSM is in CAPTURE.
          rd_en   <= 1'b0;
          state_r <= CAPTURE;
        end

        CAPTURE: begin
          tx_data <= rd_data;
`ifdef READBACK_CHECKSUM_EN
          checksum_r <= xor_accum(checksum_r, rd_data);
`endif
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state_r  <= WAIT_TX;
          end else begin
            state_r  <= SEND;
          end
        end

        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state_r  <= WAIT_TX;
          end else begin
            tx_start <= 1'b0;
            state_r  <= SEND;
          end
        end

        WAIT_TX: begin
          tx_start <= 1'b0;
          if (tx_done) begin
`ifdef READBACK_CHECKSUM_EN
            if (chk_phase_r) begin
              done    <= 1'b1;
              state_r <= FINISH;
            end else if (rd_addr == LAST_ADDR) begin
              state_r <= CHKSUM;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              rd_en   <= 1'b1;
              state_r <= FETCH;
            end
`else
            if (rd_addr == LAST_ADDR) begin
              done    <= 1'b1;
              state_r <= FINISH;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              rd_en   <= 1'b1;
              state_r <= FETCH;
            end
`endif
          end else begin
            state_r <= WAIT_TX;
          end
        end

`ifdef READBACK_CHECKSUM_EN
        CHKSUM: begin
          tx_data     <= checksum_r;
          chk_phase_r <= 1'b1;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state_r  <= WAIT_TX;
          end else begin
            state_r  <= SEND;
          end
        end
`endif

        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          // Unreachable encodings recover to a clean idle state.
          state_r  <= IDLE;
          rd_en    <= 1'b0;
          rd_addr  <= '0;
          tx_start <= 1'b0;
          tx_data  <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_readback_tx.sv
// -----------------------------------------------------------------------------
// tb_weight_readback_tx
// Directed bench for weight_readback_tx. It uses three instances:
//   0: NUM_BYTES=64, memory holds addr^8'hA5 (basic, back-pressure,
//      start-while-busy and reset tests)
//   1: NUM_BYTES=4,  memory holds addr+1   (checksum test)
//   2: NUM_BYTES=1,  memory holds 8'h3C    (minimum-size test)
// A behavioural UART TX stays busy for bt[i] cycles after each tx_start and
// then pulses tx_done.
// -----------------------------------------------------------------------------
module tb_weight_readback_tx;

`ifdef READBACK_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk;
  logic       reset_n_v  [3];
  logic       start_v    [3];
  logic       rd_en_v    [3];
  logic [7:0] rd_addr_v  [3];
  logic [7:0] rd_data_v  [3];
  logic       tx_start_v [3];
  logic [7:0] tx_data_v  [3];
  logic       tx_busy_v  [3];
  logic       tx_done_v  [3];
  logic       busy_v     [3];
  logic       done_v     [3];

  logic       hold_busy  [3];
  int         bt         [3];
  int         cnt        [3] = '{0, 0, 0};
  logic       uart_done  [3] = '{1'b0, 1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         cyc = 0;
  int         n_start    [3] = '{0, 0, 0};
  int         n_rd_en    [3] = '{0, 0, 0};
  int         n_done     [3] = '{0, 0, 0};
  int         n_txdone   [3] = '{0, 0, 0};
  int         consec_err [3] = '{0, 0, 0};
  int         stab_err   [3] = '{0, 0, 0};
  int         done_cyc   [3] = '{0, 0, 0};
  int         ltd_cyc    [3] = '{0, 0, 0};
  logic [7:0] max_addr   [3] = '{8'h00, 8'h00, 8'h00};
  logic       prev_start [3] = '{1'b0, 1'b0, 1'b0};
  logic       in_tx      [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] latched    [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] sent       [3][512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 64 : ((g == 1) ? 4 : 1);
    weight_readback_tx #(.NUM_BYTES(NB), .ADDR_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n_v[g]), .start(start_v[g]),
      .rd_en(rd_en_v[g]), .rd_addr(rd_addr_v[g]), .rd_data(rd_data_v[g]),
      .tx_start(tx_start_v[g]), .tx_data(tx_data_v[g]),
      .tx_busy(tx_busy_v[g]), .tx_done(tx_done_v[g]),
      .busy(busy_v[g]), .done(done_v[g])
    );
    assign tx_busy_v[g] = (cnt[g] != 0) || hold_busy[g];
    assign tx_done_v[g] = uart_done[g];
  end

  function automatic logic [7:0] mem_val(input int i, input logic [7:0] a);
    case (i)
      0:       return a ^ 8'hA5;
      1:       return a + 8'd1;
      default: return 8'h3C;
    endcase
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rd_en_v[i] === 1'b1) rd_data_v[i] <= mem_val(i, rd_addr_v[i]);
  end

  // UART TX model: busy for bt cycles after tx_start, then one tx_done pulse.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      uart_done[i] <= 1'b0;
      if (tx_start_v[i] === 1'b1) cnt[i] <= bt[i];
      else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) uart_done[i] <= 1'b1;
      end
    end
  end

  // Monitor: collects pulses, transmitted bytes and protocol violations.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (tx_start_v[i] === 1'b1) begin
        if (prev_start[i]) consec_err[i] = consec_err[i] + 1;
        if (n_start[i] < 512) sent[i][n_start[i]] = tx_data_v[i];
        n_start[i] = n_start[i] + 1;
        latched[i] = tx_data_v[i];
        in_tx[i]   = 1'b1;
      end else if (in_tx[i] && busy_v[i] === 1'b1 && tx_data_v[i] !== latched[i]) begin
        stab_err[i] = stab_err[i] + 1;
      end
      prev_start[i] = (tx_start_v[i] === 1'b1);
      if (busy_v[i] !== 1'b1) in_tx[i] = 1'b0;
      if (tx_done_v[i] === 1'b1) begin
        n_txdone[i] = n_txdone[i] + 1;
        ltd_cyc[i]  = cyc;
        in_tx[i]    = 1'b0;
      end
      if (rd_en_v[i] === 1'b1) begin
        n_rd_en[i] = n_rd_en[i] + 1;
        if (rd_addr_v[i] > max_addr[i]) max_addr[i] = rd_addr_v[i];
      end
      if (done_v[i] === 1'b1) begin
        n_done[i]   = n_done[i] + 1;
        done_cyc[i] = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns one cycle after start was sampled (cycle 1).
  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    step();
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int k;
    k = 0;
    while (done_v[i] !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk("done_reached", {31'd0, done_v[i]}, 32'd1);
  endtask

  task automatic wait_starts(input int i, input int target, input int lim);
    int k;
    k = 0;
    while (n_start[i] < target && k < lim) begin
      step();
      k++;
    end
    chk("start_count_reached", (n_start[i] >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int b_start, b_rd, b_done, b_stab, b_txd, bad;

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_n_v[i] = 1'b0;
      start_v[i]   = 1'b0;
      hold_busy[i] = 1'b0;
    end
    bt[0] = 10; bt[1] = 2; bt[2] = 4;
    repeat (3) step();

    // Reset values
    chk("rst_rd_en",    {31'd0, rd_en_v[0]},    32'd0);
    chk("rst_rd_addr",  {24'd0, rd_addr_v[0]},  32'd0);
    chk("rst_tx_start", {31'd0, tx_start_v[0]}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data_v[0]},  32'd0);
    chk("rst_busy",     {31'd0, busy_v[0]},     32'd0);
    chk("rst_done",     {31'd0, done_v[0]},     32'd0);
    for (int i = 0; i < 3; i++) reset_n_v[i] = 1'b1;
    step();

    // ---------------- Basic readback, first-byte timing ----------------
    b_start = n_start[0]; b_done = n_done[0];
    pulse_start(0);
    chk("c1_rd_en", {31'd0, rd_en_v[0]}, 32'd1);
    chk("c1_busy",  {31'd0, busy_v[0]},  32'd1);
    step();
    chk("c2_rd_en", {31'd0, rd_en_v[0]}, 32'd0);
    step();
    chk("c3_tx_start", {31'd0, tx_start_v[0]}, 32'd1);
    chk("c3_tx_data",  {24'd0, tx_data_v[0]},  32'hA5);
    for (int k = 0; k < 50 && tx_done_v[0] !== 1'b1; k++) step();
    step();
    chk("gap_rd_en",   {31'd0, rd_en_v[0]},   32'd1);
    chk("gap_rd_addr", {24'd0, rd_addr_v[0]}, 32'd1);
    wait_done(0, 3000);
    chk("basic_done_latency", done_cyc[0] - ltd_cyc[0], 32'd1);
    step();
    chk("basic_busy_low", {31'd0, busy_v[0]}, 32'd0);
    chk("basic_done_low", {31'd0, done_v[0]}, 32'd0);
    chk("basic_n_start", n_start[0] - b_start, 64 + CK);
    chk("basic_n_done",  n_done[0] - b_done, 32'd1);
    bad = 0;
    for (int a = 0; a < 64; a++)
      if (sent[0][b_start + a] !== (a[7:0] ^ 8'hA5)) bad++;
    chk("basic_bytes", bad, 32'd0);
    if (CK == 1) chk("basic_checksum", {24'd0, sent[0][b_start + 64]}, 32'h00);
    chk("basic_max_addr", {24'd0, max_addr[0]}, 32'd63);

    // -------- Back-pressure on the first byte, then start during byte 5 --------
    bt[0] = 3;
    b_start = n_start[0]; b_done = n_done[0]; b_stab = stab_err[0]; b_rd = n_rd_en[0];
    hold_busy[0] = 1'b1;
    pulse_start(0);
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      if (tx_start_v[0] !== 1'b0) bad++;
      step();
    end
    chk("bp_no_early_start", bad, 32'd0);
    hold_busy[0] = 1'b0;
    step();
    chk("bp_tx_start", {31'd0, tx_start_v[0]}, 32'd1);
    chk("bp_tx_data",  {24'd0, tx_data_v[0]},  32'hA5);
    wait_starts(0, b_start + 6, 500);
    step();
    pulse_start(0);
    wait_done(0, 3000);
    step();
    chk("restart_n_start", n_start[0] - b_start, 64 + CK);
    chk("restart_n_rd_en", n_rd_en[0] - b_rd, 32'd64);
    chk("restart_n_done",  n_done[0] - b_done, 32'd1);
    chk("bp_stable",       stab_err[0] - b_stab, 32'd0);
    bad = 0;
    for (int a = 0; a < 64; a++)
      if (sent[0][b_start + a] !== (a[7:0] ^ 8'hA5)) bad++;
    chk("restart_bytes", bad, 32'd0);
    chk("no_back_to_back_start", consec_err[0], 32'd0);

    // ---------------- Reset during byte 30's WAIT_TX ----------------
    bt[0] = 10;
    b_start = n_start[0];
    pulse_start(0);
    wait_starts(0, b_start + 31, 2000);
    step();
    reset_n_v[0] = 1'b0;
    step();
    reset_n_v[0] = 1'b1;
    chk("mr_rd_en",    {31'd0, rd_en_v[0]},    32'd0);
    chk("mr_rd_addr",  {24'd0, rd_addr_v[0]},  32'd0);
    chk("mr_tx_start", {31'd0, tx_start_v[0]}, 32'd0);
    chk("mr_tx_data",  {24'd0, tx_data_v[0]},  32'd0);
    chk("mr_busy",     {31'd0, busy_v[0]},     32'd0);
    chk("mr_done",     {31'd0, done_v[0]},     32'd0);
    b_rd = n_rd_en[0]; b_start = n_start[0]; b_txd = n_txdone[0];
    repeat (15) step();
    chk("late_done_seen",    (n_txdone[0] > b_txd) ? 32'd1 : 32'd0, 32'd1);
    chk("late_done_idle",    {31'd0, busy_v[0]}, 32'd0);
    chk("late_done_no_read", n_rd_en[0] - b_rd, 32'd0);
    chk("late_done_no_tx",   n_start[0] - b_start, 32'd0);
    b_done = n_done[0];
    pulse_start(0);
    chk("fresh_rd_en",   {31'd0, rd_en_v[0]},   32'd1);
    chk("fresh_rd_addr", {24'd0, rd_addr_v[0]}, 32'd0);
    wait_done(0, 3000);
    step();
    chk("fresh_n_start", n_start[0] - b_start, 64 + CK);
    chk("fresh_n_done",  n_done[0] - b_done, 32'd1);
    bad = 0;
    for (int a = 0; a < 64; a++)
      if (sent[0][b_start + a] !== (a[7:0] ^ 8'hA5)) bad++;
    chk("fresh_bytes", bad, 32'd0);

    // ---------------- Checksum instance: 01..04 ----------------
    pulse_start(1);
    wait_done(1, 500);
    step();
    chk("ck_n_start", n_start[1], 4 + CK);
    chk("ck_n_done",  n_done[1], 32'd1);
    bad = 0;
    for (int a = 0; a < 4; a++)
      if (sent[1][a] !== 8'(a + 1)) bad++;
    chk("ck_bytes", bad, 32'd0);
    if (CK == 1) chk("ck_checksum_byte", {24'd0, sent[1][4]}, 32'h04);

    // ---------------- Minimum size: NUM_BYTES=1 ----------------
    pulse_start(2);
    chk("min_rd_en", {31'd0, rd_en_v[2]}, 32'd1);
    wait_done(2, 500);
    chk("min_done_latency", done_cyc[2] - ltd_cyc[2], 32'd1);
    step();
    chk("min_n_rd_en", n_rd_en[2], 32'd1);
    chk("min_n_start", n_start[2], 1 + CK);
    chk("min_byte",    {24'd0, sent[2][0]}, 32'h3C);
    chk("min_busy_low", {31'd0, busy_v[2]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
